mem_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the unaligned-capable cache core, in the MEM stage.
- Accepts one RV64 load/store per transaction from the pipeline and decodes funct3 into the cache byte count (0~7 means 1~8 bytes).
- Drives the cache four-phase req/ack handshake, then masks and sign/zero-extends the read data.
- Stalls the pipeline with a busy flag while a transaction is outstanding.

---
 rtl/mem_lsu.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// ----------------------------------------------------------------------------
// mem_lsu -- MEM-stage load/store unit in front of the unaligned-capable cache
//
// Accepts one RV64 load or store per transaction from the pipeline. It decodes
// funct3 into a cache byte count (value 0..7 means 1..8 bytes) and runs a
// four-phase req/ack handshake with the cache core. The returned load data is
// masked and sign- or zero-extended. The pipeline is stalled through
// o_lsu_busy while a transaction is outstanding.
//
// Optional feature (compile-time macro LSU_MISALIGN_TRAP_EN):
//   defined   : a LH/LW/LD (or SH/SW/SD) whose address is not aligned to the
//               access size goes straight to DONE. No cache request is
//               issued, and o_lsu_misalign is raised with o_lsu_done and a
//               zero result.
//   undefined : o_lsu_misalign is tied low. Every alignment is passed to the
//               cache core, which splits line-crossing accesses itself.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   i_lsu_valid         pipeline presents a memory op
//   i_lsu_op            0 = load, 1 = store
//   i_lsu_funct3        RV64 funct3
//   i_lsu_addr          byte address, any alignment
//   i_lsu_wdata         right-aligned store data
//   o_lsu_ready         high in IDLE; accept = i_lsu_valid & o_lsu_ready
//   o_lsu_busy          stall request (REQ / RELEASE / DONE)
//   o_lsu_done          one-cycle completion pulse
//   o_lsu_rdata         extended load result with o_lsu_done, 0 for stores
//   o_lsu_misalign      misaligned-access flag with o_lsu_done
//   o_cache_top_*       request side of the cache handshake
//   i_cache_top_rdata   cache read data; only the low bytes are meaningful
//   i_cache_top_ack     cache acknowledge
// ----------------------------------------------------------------------------
module mem_lsu #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_lsu_valid,
    input  logic              i_lsu_op,
    input  logic [2:0]        i_lsu_funct3,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic [ADDR_W-1:0] i_lsu_wdata,
    output logic              o_lsu_ready,
    output logic              o_lsu_busy,
    output logic              o_lsu_done,
    output logic [ADDR_W-1:0] o_lsu_rdata,
    output logic              o_lsu_misalign,
    output logic [ADDR_W-1:0] o_cache_top_addr,
    output logic [ADDR_W-1:0] o_cache_top_wdata,
    output logic [2:0]        o_cache_top_bytes,
    output logic              o_cache_top_op,
    output logic              o_cache_top_req,
    input  logic [ADDR_W-1:0] i_cache_top_rdata,
    input  logic              i_cache_top_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_DONE
    } state_t;

    // Byte count minus one. A store with funct3[2] set is illegal and is
    // treated as SD-size. Load funct3 3'b111 already lands on size 7 through
    // funct3[1:0].
    function automatic logic [2:0] decode_bytes(input logic op, input logic [2:0] f3);
        logic [2:0] b;
        case (f3[1:0])
            2'd0:    b = 3'd0;
            2'd1:    b = 3'd1;
            2'd2:    b = 3'd3;
            default: b = 3'd7;
        endcase
        if (op && f3[2]) begin
            b = 3'd7;
        end
        return b;
    endfunction

    // Masks the raw cache data to bytes+1 bytes, then extends it. The byte
    // count only ever takes the values 0, 1, 3 and 7. Full width needs no
    // extension.
    function automatic logic [ADDR_W-1:0] load_extend(input logic [ADDR_W-1:0] raw,
                                                      input logic [2:0]        bytes,
                                                      input logic              uns);
        logic [ADDR_W-1:0] res;
        case (bytes)
            3'd0:    res = uns ? {{(ADDR_W-8){1'b0}}, raw[7:0]}
                               : {{(ADDR_W-8){raw[7]}}, raw[7:0]};
            3'd1:    res = uns ? {{(ADDR_W-16){1'b0}}, raw[15:0]}
                               : {{(ADDR_W-16){raw[15]}}, raw[15:0]};
            3'd3:    res = uns ? {{(ADDR_W-32){1'b0}}, raw[31:0]}
                               : {{(ADDR_W-32){raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] bytes, input logic [2:0] addr_lo);
        logic mis;
        case (bytes)
            3'd1:    mis = addr_lo[0];
            3'd3:    mis = |addr_lo[1:0];
            3'd7:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
`endif

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [ADDR_W-1:0] wdata_q,    wdata_d;
    logic [2:0]        bytes_q,    bytes_d;
    logic              op_q,       op_d;
    logic              load_uns_q, load_uns_d;
    logic              req_q,      req_d;
    logic [ADDR_W-1:0] raw_q,      raw_d;
    logic [ADDR_W-1:0] rdata_q,    rdata_d;
    logic              ready_q,    ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;
    logic [2:0]        acc_bytes;
`endif

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_bytes = decode_bytes(i_lsu_op, i_lsu_funct3);
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bytes_d    = bytes_q;
        op_d       = op_q;
        load_uns_d = load_uns_q;
        req_d      = req_q;
        raw_d      = raw_q;
        rdata_d    = rdata_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_lsu_valid) begin
                    addr_d     = i_lsu_addr;
                    wdata_d    = i_lsu_wdata;
                    bytes_d    = decode_bytes(i_lsu_op, i_lsu_funct3);
                    op_d       = i_lsu_op;
                    load_uns_d = i_lsu_funct3[2];
                    rdata_d    = '0;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(acc_bytes, i_lsu_addr[2:0])) begin
                        // Trap path: skip the cache and complete next cycle.
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end
`else
                    state_d = S_REQ;
                    req_d   = 1'b1;
`endif
                end
            end
            S_REQ: begin
                // The cache outputs stay frozen until the cache acknowledges.
                if (i_cache_top_ack) begin
                    raw_d   = i_cache_top_rdata;
                    req_d   = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The cache drops ack only after req has fallen. Its data bus
                // may already be junk here, so the captured raw_q is used.
                if (!i_cache_top_ack) begin
                    rdata_d = op_q ? '0 : load_extend(raw_q, bytes_q, load_uns_q);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_d = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            bytes_q    <= '0;
            op_q       <= 1'b0;
            load_uns_q <= 1'b0;
            req_q      <= 1'b0;
            raw_q      <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bytes_q    <= bytes_d;
            op_q       <= op_d;
            load_uns_q <= load_uns_d;
            req_q      <= req_d;
            raw_q      <= raw_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign o_lsu_ready       = ready_q;
    assign o_lsu_busy        = busy_q;
    assign o_lsu_done        = done_q;
    assign o_lsu_rdata       = rdata_q;
    assign o_cache_top_addr  = addr_q;
    assign o_cache_top_wdata = wdata_q;
    assign o_cache_top_bytes = bytes_q;
    assign o_cache_top_op    = op_q;
    assign o_cache_top_req   = req_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign o_lsu_misalign    = misalign_q;
`else
    assign o_lsu_misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// ----------------------------------------------------------------------------
// tb_mem_lsu -- scoreboard bench for mem_lsu
//
// Stimulus pushes the expected cache request and the expected completion into
// queues. Separate monitor processes pop and compare them whenever the DUT
// raises o_cache_top_req or o_lsu_done. A small cache responder answers the
// handshake with programmable ack and release delays.
// ----------------------------------------------------------------------------
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        i_lsu_valid;
    logic        i_lsu_op;
    logic [2:0]  i_lsu_funct3;
    logic [63:0] i_lsu_addr;
    logic [63:0] i_lsu_wdata;
    logic        o_lsu_ready;
    logic        o_lsu_busy;
    logic        o_lsu_done;
    logic [63:0] o_lsu_rdata;
    logic        o_lsu_misalign;
    logic [63:0] o_cache_top_addr;
    logic [63:0] o_cache_top_wdata;
    logic [2:0]  o_cache_top_bytes;
    logic        o_cache_top_op;
    logic        o_cache_top_req;
    logic [63:0] i_cache_top_rdata;
    logic        i_cache_top_ack;

    mem_lsu #(.ADDR_W(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_lsu_valid       (i_lsu_valid),
        .i_lsu_op          (i_lsu_op),
        .i_lsu_funct3      (i_lsu_funct3),
        .i_lsu_addr        (i_lsu_addr),
        .i_lsu_wdata       (i_lsu_wdata),
        .o_lsu_ready       (o_lsu_ready),
        .o_lsu_busy        (o_lsu_busy),
        .o_lsu_done        (o_lsu_done),
        .o_lsu_rdata       (o_lsu_rdata),
        .o_lsu_misalign    (o_lsu_misalign),
        .o_cache_top_addr  (o_cache_top_addr),
        .o_cache_top_wdata (o_cache_top_wdata),
        .o_cache_top_bytes (o_cache_top_bytes),
        .o_cache_top_op    (o_cache_top_op),
        .o_cache_top_req   (o_cache_top_req),
        .i_cache_top_rdata (i_cache_top_rdata),
        .i_cache_top_ack   (i_cache_top_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  bytes;
        logic        op;
    } req_exp_t;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          lat;
    } done_exp_t;

    req_exp_t  req_q[$];
    done_exp_t done_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cyc     = 0;
    int done_cnt    = 0;
    bit in_flight   = 1'b0;

    // Cache responder configuration, written by the stimulus before each op.
    logic [63:0] rsp_raw  = '0;
    int          rsp_ackd = 1;
    int          rsp_reld = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Cache responder: ack rsp_ackd cycles after req rises, then release
    // rsp_reld cycles after req falls. The data bus turns to junk on release.
    initial begin
        int rs;
        int cnt;
        rs  = 0;
        cnt = 0;
        i_cache_top_ack   = 1'b0;
        i_cache_top_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                rs = 0;
                i_cache_top_ack = 1'b0;
            end else begin
                case (rs)
                    0: if (o_cache_top_req) begin
                        cnt = rsp_ackd;
                        rs  = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt <= 0) begin
                            i_cache_top_ack   = 1'b1;
                            i_cache_top_rdata = rsp_raw;
                            rs = 2;
                        end
                    end
                    2: if (!o_cache_top_req) begin
                        cnt = rsp_reld;
                        rs  = 3;
                    end
                    default: begin
                        cnt--;
                        if (cnt <= 0) begin
                            i_cache_top_ack   = 1'b0;
                            i_cache_top_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
                            rs = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: busy/ready tracking, request scoreboard with stability checks,
    // and completion scoreboard with latency and single-pulse checks.
    initial begin
        logic     req_prev;
        logic     done_prev;
        req_exp_t cur;
        req_exp_t re;
        done_exp_t de;
        req_prev  = 1'b0;
        done_prev = 1'b0;
        cur = '{addr: '0, wdata: '0, bytes: '0, op: 1'b0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                req_prev  = 1'b0;
                done_prev = 1'b0;
            end else begin
                check("busy", {63'd0, o_lsu_busy}, {63'd0, in_flight});
                check("ready", {63'd0, o_lsu_ready}, {63'd0, !in_flight});
                if (o_cache_top_req && !req_prev) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 64'd1, 64'd0);
                    end else begin
                        re = req_q.pop_front();
                        cur = re;
                        check("req_addr", o_cache_top_addr, re.addr);
                        check("req_wdata", o_cache_top_wdata, re.wdata);
                        check("req_bytes", {61'd0, o_cache_top_bytes}, {61'd0, re.bytes});
                        check("req_op", {63'd0, o_cache_top_op}, {63'd0, re.op});
                    end
                end else if (o_cache_top_req) begin
                    check("req_hold_addr", o_cache_top_addr, cur.addr);
                    check("req_hold_wdata", o_cache_top_wdata, cur.wdata);
                end
                if (o_lsu_done) begin
                    check("done_once", {63'd0, done_prev}, 64'd0);
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        de = done_q.pop_front();
                        check("rdata", o_lsu_rdata, de.rdata);
                        check("misalign", {63'd0, o_lsu_misalign}, {63'd0, de.mis});
                        check("latency", 64'(cyc - acc_cyc), 64'(de.lat));
                    end
                    in_flight = 1'b0;
                    done_cnt++;
                end
                req_prev  = o_cache_top_req;
                done_prev = o_lsu_done;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!o_lsu_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_lsu_ready) check("ready_timeout", 64'd0, 64'd1);
    endtask

    // Issues one op, pushes its expectations and waits (bounded) for done.
    // With poke set, valid is raised with a different op while busy.
    task automatic issue(input logic op, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] raw, input int ackd, input int reld,
                         input logic [63:0] exp_rd, input logic [2:0] exp_b,
                         input logic exp_mis, input bit poke);
        int target;
        int n;
        rsp_raw  = raw;
        rsp_ackd = ackd;
        rsp_reld = reld;
        if (!exp_mis) begin
            req_q.push_back('{addr: addr, wdata: wdata, bytes: exp_b, op: op});
            done_q.push_back('{rdata: exp_rd, mis: 1'b0, lat: ackd + reld + 2});
        end else begin
            done_q.push_back('{rdata: 64'd0, mis: 1'b1, lat: 0});
        end
        wait_ready();
        target = done_cnt + 1;
        @(posedge clk);
        #1;
        i_lsu_valid  = 1'b1;
        i_lsu_op     = op;
        i_lsu_funct3 = f3;
        i_lsu_addr   = addr;
        i_lsu_wdata  = wdata;
        @(posedge clk);
        #1;
        i_lsu_valid = 1'b0;
        acc_cyc     = cyc;
        in_flight   = 1'b1;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1;
            i_lsu_valid  = 1'b1;
            i_lsu_op     = 1'b0;
            i_lsu_funct3 = 3'd0;
            i_lsu_addr   = 64'h0000_0000_0000_1234;
            repeat (5) @(posedge clk);
            #1;
            i_lsu_valid = 1'b0;
        end
        n = 0;
        while (done_cnt < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic lw_mis;
`ifdef LSU_MISALIGN_TRAP_EN
        lw_mis = 1'b1;
`else
        lw_mis = 1'b0;
`endif
        rst          = 1'b0;
        i_lsu_valid  = 1'b0;
        i_lsu_op     = 1'b0;
        i_lsu_funct3 = 3'd0;
        i_lsu_addr   = '0;
        i_lsu_wdata  = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", {63'd0, o_lsu_ready}, 64'd1);
        check("rst_busy", {63'd0, o_lsu_busy}, 64'd0);
        check("rst_done", {63'd0, o_lsu_done}, 64'd0);
        check("rst_req", {63'd0, o_cache_top_req}, 64'd0);
        check("rst_rdata", o_lsu_rdata, 64'd0);
        check("rst_addr", o_cache_top_addr, 64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // op f3 addr wdata raw ackd reld exp_rdata bytes mis poke
        issue(0, 3'd3, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1, 1,
              64'h1122_3344_5566_7788, 3'd7, 0, 0);                        // LD
        issue(0, 3'd0, 64'h8000_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1, 1,
              64'hFFFF_FFFF_FFFF_FF80, 3'd0, 0, 0);                        // LB
        issue(0, 3'd4, 64'h8000_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1, 1,
              64'h0000_0000_0000_0080, 3'd0, 0, 0);                        // LBU
        issue(0, 3'd2, 64'h8000_000E, 64'd0, 64'hDEAD_BEEF_8000_0001, 1, 1,
              64'hFFFF_FFFF_8000_0001, 3'd3, lw_mis, 0);                   // LW unaligned
        issue(1, 3'd1, 64'h8000_0010, 64'h0000_0000_0000_ABCD, 64'h5555_5555_5555_5555, 1, 1,
              64'd0, 3'd1, 0, 0);                                          // SH
        issue(0, 3'd1, 64'h8000_0020, 64'd0, 64'h0000_0000_1234_8001, 1, 1,
              64'hFFFF_FFFF_FFFF_8001, 3'd1, 0, 0);                        // LH
        issue(0, 3'd5, 64'h8000_0020, 64'd0, 64'h0000_0000_1234_8001, 1, 1,
              64'h0000_0000_0000_8001, 3'd1, 0, 0);                        // LHU
        issue(0, 3'd6, 64'h8000_0024, 64'd0, 64'hDEAD_BEEF_8000_0001, 2, 1,
              64'h0000_0000_8000_0001, 3'd3, 0, 0);                        // LWU
        issue(0, 3'd2, 64'h8000_0028, 64'd0, 64'hFFFF_FFFF_7FFF_FFFF, 1, 2,
              64'h0000_0000_7FFF_FFFF, 3'd3, 0, 0);                        // LW positive
        issue(0, 3'd0, 64'h8000_0005, 64'd0, 64'hAAAA_AAAA_AAAA_AA7F, 1, 1,
              64'h0000_0000_0000_007F, 3'd0, 0, 0);                        // LB positive
        issue(0, 3'd7, 64'h8000_0030, 64'd0, 64'hF000_0000_0000_0001, 1, 1,
              64'hF000_0000_0000_0001, 3'd7, 0, 0);                        // illegal load
        issue(1, 3'd0, 64'h8000_0031, 64'h1122_3344_5566_7788, 64'd0, 1, 1,
              64'd0, 3'd0, 0, 0);                                          // SB
        issue(1, 3'd6, 64'h8000_0038, 64'hCAFE_F00D_1234_5678, 64'd0, 1, 1,
              64'd0, 3'd7, 0, 0);                                          // illegal store
        issue(1, 3'd3, 64'h8000_0040, 64'h0102_0304_0506_0708, 64'd0, 1, 1,
              64'd0, 3'd7, 0, 0);                                          // SD
        issue(0, 3'd3, 64'h8000_0048, 64'd0, 64'h0123_4567_89AB_CDEF, 10, 3,
              64'h0123_4567_89AB_CDEF, 3'd7, 0, 1);                        // slow ack + poke

        // Stray ack while idle must not start or complete anything.
        @(posedge clk);
        #1;
        i_cache_top_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_cache_top_ack = 1'b0;
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of REQ.
        rsp_ackd = 40;
        rsp_reld = 1;
        req_q.push_back('{addr: 64'h8000_0050, wdata: 64'd0, bytes: 3'd7, op: 1'b0});
        wait_ready();
        @(posedge clk);
        #1;
        i_lsu_valid  = 1'b1;
        i_lsu_op     = 1'b0;
        i_lsu_funct3 = 3'd3;
        i_lsu_addr   = 64'h8000_0050;
        @(posedge clk);
        #1;
        i_lsu_valid = 1'b0;
        acc_cyc     = cyc;
        in_flight   = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        in_flight = 1'b0;
        #1;
        check("arst_req", {63'd0, o_cache_top_req}, 64'd0);
        check("arst_ready", {63'd0, o_lsu_ready}, 64'd1);
        check("arst_busy", {63'd0, o_lsu_busy}, 64'd0);
        check("arst_done", {63'd0, o_lsu_done}, 64'd0);
        check("arst_addr", o_cache_top_addr, 64'd0);
        check("arst_bytes", {61'd0, o_cache_top_bytes}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Recovery after reset.
        issue(0, 3'd5, 64'h8000_0060, 64'd0, 64'h0000_0000_0000_FFFE, 1, 1,
              64'h0000_0000_0000_FFFE, 3'd1, 0, 0);                        // LHU
`ifdef LSU_MISALIGN_TRAP_EN
        issue(0, 3'd3, 64'h8000_0004, 64'd0, 64'd0, 1, 1,
              64'd0, 3'd7, 1, 0);                                          // LD misaligned trap
`endif

        repeat (4) @(posedge clk);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1);
    end

endmodule
